// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller slice.
//   scan_state_e : scan FSM encoding (IDLE / BLANK / SHOW)
//   ANODE_OFF    : per-bit inactive level of a common-anode enable (active-low)
//   DP_OFF       : inactive level of the decimal point (active-low)
//   DEF_*        : default timing/geometry used by the modules below
package seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_e;

  localparam logic ANODE_OFF = 1'b1;
  localparam logic DP_OFF    = 1'b1;

  localparam int unsigned DEF_NUM_DIGITS   = 4;
  localparam int unsigned DEF_REFRESH_DIV  = 100000;
  localparam int unsigned DEF_BLANK_CYCLES = 1000;

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Slot timer for multiplexed display drivers.
// Counts 0..REFRESH_DIV-1 while run is high, wrapping to 0 after the last
// count; clear (or rst) forces the count to 0.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : synchronous restart of the slot
//   run         : advance the count this cycle
//   blank_done  : high during the last cycle of the blanking gap
//   slot_done   : high during the last cycle of the slot
module seven_seg_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic blank_done,
  output logic slot_done
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] count;

  assign blank_done = (count == CW'(BLANK_CYCLES - 1));
  assign slot_done  = (count == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run) begin
      count <= slot_done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexing scan controller for NUM_DIGITS common-anode digits that
// share one external seven-segment decoder. Each digit slot opens with a
// blanking gap (all anodes off) and then lights the digit. Display data is
// double-buffered: load writes the shadow copy, which becomes active at the
// next frame boundary (or immediately while idle).
// Optional build macro: SEVEN_SEG_LZ_BLANK_EN (leading-zero suppression).
//   clk, rst    : clock, synchronous active-high reset
//   enable      : scan enable; low forces all anodes off and returns to IDLE
//   load        : strobe capturing digit_data/dp_data into the shadow copy
//   digit_data  : BCD nibbles, digit 0 in [3:0]
//   dp_data     : decimal-point request per digit
//   bin_out     : nibble to the decoder
//   an_out      : anode enables, active-low
//   dp_out      : decimal point, active-low
//   digit_idx   : current digit index
//   frame_done  : one-cycle pulse after the last digit's slot ends
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digit_data,
  input  logic [NUM_DIGITS-1:0]         dp_data,
  output logic [3:0]                    bin_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic                          dp_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_e state, state_nxt;
  logic [IW-1:0] idx_nxt;
  logic wrap;

  logic [NUM_DIGITS-1:0][3:0] shadow, shadow_nxt, active, active_nxt;
  logic [NUM_DIGITS-1:0]      shadow_dp, shadow_dp_nxt, active_dp, active_dp_nxt;
  logic                       pending, pending_nxt;

  logic [NUM_DIGITS-1:0] an_nxt;
  logic                  dp_nxt;
  logic [3:0]            bin_nxt;
  logic                  suppress;

  logic blank_done, slot_done;

  seven_seg_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_slot_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     ((state == IDLE) || !enable),
    .run       (state != IDLE),
    .blank_done(blank_done),
    .slot_done (slot_done)
  );

  always_comb begin
    state_nxt     = state;
    idx_nxt       = digit_idx;
    wrap          = 1'b0;
    shadow_nxt    = shadow;
    shadow_dp_nxt = shadow_dp;
    active_nxt    = active;
    active_dp_nxt = active_dp;
    pending_nxt   = pending;

    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = BLANK;
          idx_nxt   = '0;
        end
      end
      BLANK: begin
        if (blank_done) state_nxt = SHOW;
      end
      SHOW: begin
        if (slot_done) begin
          state_nxt = BLANK;
          if (digit_idx == LAST_IDX) begin
            idx_nxt = '0;
            wrap    = 1'b1;
          end else begin
            idx_nxt = digit_idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      wrap      = 1'b0;
    end

    // Commit reads the current shadow, so a load on the boundary edge
    // lands in shadow and waits for the following boundary.
    if ((state == IDLE || wrap) && pending) begin
      active_nxt    = shadow;
      active_dp_nxt = shadow_dp;
      pending_nxt   = 1'b0;
    end

    if (load) begin
      shadow_nxt    = digit_data;
      shadow_dp_nxt = dp_data;
      if (state == IDLE) begin
        active_nxt    = digit_data;
        active_dp_nxt = dp_data;
        pending_nxt   = 1'b0;
      end else begin
        pending_nxt = 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // Digit k>0 stays dark when it and every higher digit are zero with no dp.
  always_comb begin
    suppress = (idx_nxt != '0);
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if ((IW'(j) >= idx_nxt) && ((active_nxt[j] != 4'd0) || active_dp_nxt[j]))
        suppress = 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // Outputs are registered from next-state values so they change on the
  // same edge as the state they describe.
  always_comb begin
    an_nxt  = {NUM_DIGITS{ANODE_OFF}};
    dp_nxt  = DP_OFF;
    bin_nxt = '0;
    if (state_nxt != IDLE) bin_nxt = active_nxt[idx_nxt];
    if (state_nxt == SHOW && !suppress) begin
      an_nxt[idx_nxt] = ~ANODE_OFF;
      dp_nxt          = ~active_dp_nxt[idx_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      digit_idx  <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      active     <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      an_out     <= {NUM_DIGITS{ANODE_OFF}};
      dp_out     <= DP_OFF;
      bin_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      digit_idx  <= idx_nxt;
      shadow     <= shadow_nxt;
      shadow_dp  <= shadow_dp_nxt;
      active     <= active_nxt;
      active_dp  <= active_dp_nxt;
      pending    <= pending_nxt;
      an_out     <= an_nxt;
      dp_out     <= dp_nxt;
      bin_out    <= bin_nxt;
      frame_done <= wrap;
    end
  end

endmodule
